// File: rtl/dmem_pkg.sv
// Shared types and address decode for the MEM-stage data-memory responder.
package dmem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } req_t;

  typedef struct packed {
    logic [WORD_W-1:0] index;
    logic              misaligned;
    logic              out_of_range;
  } decode_t;

  // aw = log2(depth); index is returned zero-extended, caller keeps the low aw bits
  function automatic decode_t decode_addr(input logic [WORD_W-1:0] addr, input int aw);
    decode_t d;
    d.index        = (addr >> 2) & ((WORD_W'(1) << aw) - WORD_W'(1));
    d.misaligned   = |addr[1:0];
    d.out_of_range = |(addr >> (aw + 2));
    return d;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word array: async clear, byte-enabled synchronous write, combinational read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);
  logic [DEPTH-1:0][WORD_W-1:0] mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem <= '0;
    end else if (we) begin
      for (int b = 0; b < BE_W; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed latency, registered response, error count.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH     = 128,
  parameter int LATENCY   = 2,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  input  logic [3:0]           req_be,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [31:0]          resp_rdata,
  output logic                 resp_err,
  input  logic                 resp_ready,
  output logic                 mem_stall,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  req_t              cap;
  decode_t           dec;
  logic              err;
  logic              fire;
  logic [WORD_W-1:0] rdata_arr;
  logic              unused_idx;

  assign dec        = decode_addr(cap.addr, AW);
  assign unused_idx = ^dec.index[WORD_W-1:AW];
  assign err        = dec.misaligned | dec.out_of_range;
  // fire marks the RESP entry edge: store commits and load data is sampled here
  assign fire       = (state == BUSY) && (cnt == '0);

  assign req_ready  = (state == IDLE);
  assign mem_stall  = ((state == IDLE) & req_valid) | (state == BUSY) |
                      ((state == RESP) & ~resp_ready);

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (fire & cap.write & ~err),
    .idx   (dec.index[AW-1:0]),
    .wdata (cap.wdata),
    .be    (cap.be),
    .rdata (rdata_arr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cap        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cap   <= '{req_write, req_addr, req_wdata, req_be};
          cnt   <= CW'(LATENCY - 1);
          state <= BUSY;
        end
        BUSY: if (cnt == '0) begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= err;
          resp_rdata <= (err | cap.write) ? '0 : rdata_arr;
          if (err && (err_count != '1)) err_count <= err_count + ERR_CNT_W'(1);
        end else begin
          cnt <= cnt - CW'(1);
        end
        RESP: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
